wait_ctrl: RTL and testbench

WAIT_CTRL -- requirements
Module: wait_ctrl

---
 rtl/wait_ctrl.sv | 143 ++++++++++++++
 tb/tb_wait_ctrl.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wait_ctrl.sv
// wait_ctrl: pipeline stall/flush controller for memory waits, divides and exceptions.
// Ports: clk, resetn (async low); i_stall, d_stall, div_start, div_done,
//   load_use, exc_req in; stall[4:0], flush[4:0] (bit0=F..bit4=W), div_cancel,
//   state[1:0] (debug), stall_cnt[31:0] out.
// Optional: define WAIT_CTRL_STALL_CNT_EN to build the saturating stall counter;
//   otherwise stall_cnt is tied to 0.
`timescale 1ns/1ps
module wait_ctrl (
    input  logic        clk,
    input  logic        resetn,
    input  logic        i_stall,
    input  logic        d_stall,
    input  logic        div_start,
    input  logic        div_done,
    input  logic        load_use,
    input  logic        exc_req,
    output logic [4:0]  stall,
    output logic [4:0]  flush,
    output logic        div_cancel,
    output logic [1:0]  state,
    output logic [31:0] stall_cnt
);

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        MEM_WAIT   = 2'd1,
        DIV_WAIT   = 2'd2,
        FLUSH_PEND = 2'd3
    } state_t;

    state_t     r_state;
    state_t     w_nxt;
    logic       r_done_q;
    logic       w_done_nxt;
    logic [4:0] w_stall;
    logic [4:0] w_flush;
    logic       w_cancel;
    logic       w_mem;

    assign w_mem = i_stall | d_stall;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state  <= RUN;
            r_done_q <= 1'b0;
        end else begin
            r_state  <= w_nxt;
            r_done_q <= w_done_nxt;
        end
    end

    always_comb begin
        w_nxt      = r_state;
        w_done_nxt = r_done_q;
        w_stall    = 5'b00000;
        w_flush    = 5'b00000;
        w_cancel   = 1'b0;
        case (r_state)
            // MEM_WAIT behaves as RUN: d_stall still high re-selects the
            // full hold, and once it drops the normal priority list applies.
            RUN, MEM_WAIT: begin
                w_nxt = RUN;
                if (exc_req && w_mem) begin
                    w_stall = 5'b11111;
                    w_nxt   = FLUSH_PEND;
                end else if (exc_req) begin
                    w_flush = 5'b01111;
                end else if (d_stall) begin
                    w_stall = 5'b11111;
                    w_nxt   = MEM_WAIT;
                end else if (div_start) begin
                    w_stall = 5'b00111;
                    w_flush = 5'b01000;
                    w_nxt   = DIV_WAIT;
                end else if (i_stall) begin
                    w_stall = 5'b00001;
                    w_flush = 5'b00010;
                end else if (load_use) begin
                    w_stall = 5'b00011;
                    w_flush = 5'b00100;
                end
            end
            DIV_WAIT: begin
                if (exc_req) begin
                    w_cancel   = 1'b1;
                    w_done_nxt = 1'b0;
                    if (w_mem) begin
                        w_stall = 5'b11111;
                        w_nxt   = FLUSH_PEND;
                    end else begin
                        w_flush = 5'b01111;
                        w_nxt   = RUN;
                    end
                end else if (d_stall) begin
                    // Remember a result that lands while M is blocked.
                    w_stall = 5'b11111;
                    if (div_done) begin
                        w_done_nxt = 1'b1;
                    end
                end else if (div_done || r_done_q) begin
                    w_done_nxt = 1'b0;
                    w_nxt      = RUN;
                end else begin
                    w_stall = 5'b00111;
                    w_flush = 5'b01000;
                end
            end
            FLUSH_PEND: begin
                if (w_mem) begin
                    w_stall = 5'b11111;
                end else begin
                    w_flush = 5'b01111;
                    w_nxt   = RUN;
                end
            end
            default: begin
                w_nxt = RUN;
            end
        endcase
    end

    assign stall      = resetn ? w_stall : 5'b00000;
    assign flush      = resetn ? w_flush : 5'b00000;
    assign div_cancel = resetn & w_cancel;
    assign state      = r_state;

`ifdef WAIT_CTRL_STALL_CNT_EN
    logic [31:0] r_stall_cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_stall_cnt <= 32'd0;
        end else if ((|stall) && (r_stall_cnt != 32'hFFFF_FFFF)) begin
            r_stall_cnt <= r_stall_cnt + 32'd1;
        end
    end

    assign stall_cnt = r_stall_cnt;
`else
    assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_wait_ctrl.sv
// tb_wait_ctrl: directed self-checking bench for wait_ctrl.
// Vectors: {i_stall,d_stall,div_start,div_done,load_use,exc_req} -> {state,stall,flush,div_cancel}.
`timescale 1ns/1ps
module tb_wait_ctrl;

    logic        clk;
    logic        resetn;
    logic        i_stall;
    logic        d_stall;
    logic        div_start;
    logic        div_done;
    logic        load_use;
    logic        exc_req;
    logic [4:0]  stall;
    logic [4:0]  flush;
    logic        div_cancel;
    logic [1:0]  state;
    logic [31:0] stall_cnt;

    int          errors;
    int          checks;
    int          exp_cnt;
    logic [12:0] obs;

    wait_ctrl dut (
        .clk        (clk),
        .resetn     (resetn),
        .i_stall    (i_stall),
        .d_stall    (d_stall),
        .div_start  (div_start),
        .div_done   (div_done),
        .load_use   (load_use),
        .exc_req    (exc_req),
        .stall      (stall),
        .flush      (flush),
        .div_cancel (div_cancel),
        .state      (state),
        .stall_cnt  (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        resetn = 1'b0;
        {i_stall, d_stall, div_start, div_done, load_use, exc_req} = 6'b111111;
        #2;
        obs = {state, stall, flush, div_cancel};
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL reset_outputs got %h want %h", obs, 13'd0);
        end
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL reset_cnt got %0d want 0", stall_cnt);
        end
        @(posedge clk);
        #1;
        obs = {state, stall, flush, div_cancel};
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL reset_hold got %h want %h", obs, 13'd0);
        end
        @(negedge clk);
        resetn = 1'b1;
        {i_stall, d_stall, div_start, div_done, load_use, exc_req} = 6'b000000;
        exp_cnt = 0;
        #1;
        obs = {state, stall, flush, div_cancel};
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL reset_release got %h want %h", obs, 13'd0);
        end
    endtask

    task automatic test_load_use();
        logic [5:0]  vi [2];
        logic [12:0] ve [2];
        vi = '{6'b000010, 6'b000000};
        ve = '{{2'd0, 5'b00011, 5'b00100, 1'b0}, 13'd0};
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            {i_stall, d_stall, div_start, div_done, load_use, exc_req} = vi[k];
            #1;
            obs = {state, stall, flush, div_cancel};
            if (ve[k][10:6] != 5'd0) exp_cnt++;
            checks++;
            if (obs !== ve[k]) begin
                errors++;
                $display("FAIL load_use[%0d] got %h want %h", k, obs, ve[k]);
            end
        end
    endtask

    task automatic test_fetch_wait();
        logic [5:0]  vi [3];
        logic [12:0] ve [3];
        vi = '{6'b100000, 6'b100010, 6'b000000};
        ve = '{{2'd0, 5'b00001, 5'b00010, 1'b0},
               {2'd0, 5'b00001, 5'b00010, 1'b0},
               13'd0};
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            {i_stall, d_stall, div_start, div_done, load_use, exc_req} = vi[k];
            #1;
            obs = {state, stall, flush, div_cancel};
            if (ve[k][10:6] != 5'd0) exp_cnt++;
            checks++;
            if (obs !== ve[k]) begin
                errors++;
                $display("FAIL fetch_wait[%0d] got %h want %h", k, obs, ve[k]);
            end
        end
    endtask

    task automatic test_mem_wait();
        logic [5:0]  vi [5];
        logic [12:0] ve [5];
        vi = '{6'b010000, 6'b010000, 6'b010000, 6'b000000, 6'b000000};
        ve = '{{2'd0, 5'b11111, 5'b00000, 1'b0},
               {2'd1, 5'b11111, 5'b00000, 1'b0},
               {2'd1, 5'b11111, 5'b00000, 1'b0},
               {2'd1, 5'b00000, 5'b00000, 1'b0},
               13'd0};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            {i_stall, d_stall, div_start, div_done, load_use, exc_req} = vi[k];
            #1;
            obs = {state, stall, flush, div_cancel};
            if (ve[k][10:6] != 5'd0) exp_cnt++;
            checks++;
            if (obs !== ve[k]) begin
                errors++;
                $display("FAIL mem_wait[%0d] got %h want %h", k, obs, ve[k]);
            end
        end
    endtask

    task automatic test_divide();
        logic [5:0]  vi [6];
        logic [12:0] ve [6];
        vi = '{6'b001000, 6'b000000, 6'b000000, 6'b000000, 6'b000100, 6'b000000};
        ve = '{{2'd0, 5'b00111, 5'b01000, 1'b0},
               {2'd2, 5'b00111, 5'b01000, 1'b0},
               {2'd2, 5'b00111, 5'b01000, 1'b0},
               {2'd2, 5'b00111, 5'b01000, 1'b0},
               {2'd2, 5'b00000, 5'b00000, 1'b0},
               13'd0};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            {i_stall, d_stall, div_start, div_done, load_use, exc_req} = vi[k];
            #1;
            obs = {state, stall, flush, div_cancel};
            if (ve[k][10:6] != 5'd0) exp_cnt++;
            checks++;
            if (obs !== ve[k]) begin
                errors++;
                $display("FAIL divide[%0d] got %h want %h", k, obs, ve[k]);
            end
        end
    endtask

    task automatic test_div_mem_overlap();
        logic [5:0]  vi [6];
        logic [12:0] ve [6];
        vi = '{6'b001000, 6'b010000, 6'b010100, 6'b010000, 6'b000000, 6'b000000};
        ve = '{{2'd0, 5'b00111, 5'b01000, 1'b0},
               {2'd2, 5'b11111, 5'b00000, 1'b0},
               {2'd2, 5'b11111, 5'b00000, 1'b0},
               {2'd2, 5'b11111, 5'b00000, 1'b0},
               {2'd2, 5'b00000, 5'b00000, 1'b0},
               13'd0};
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            {i_stall, d_stall, div_start, div_done, load_use, exc_req} = vi[k];
            #1;
            obs = {state, stall, flush, div_cancel};
            if (ve[k][10:6] != 5'd0) exp_cnt++;
            checks++;
            if (obs !== ve[k]) begin
                errors++;
                $display("FAIL div_mem[%0d] got %h want %h", k, obs, ve[k]);
            end
        end
    endtask

    task automatic test_exc_fetch();
        logic [5:0]  vi [5];
        logic [12:0] ve [5];
        vi = '{6'b100001, 6'b100000, 6'b100001, 6'b000000, 6'b000000};
        ve = '{{2'd0, 5'b11111, 5'b00000, 1'b0},
               {2'd3, 5'b11111, 5'b00000, 1'b0},
               {2'd3, 5'b11111, 5'b00000, 1'b0},
               {2'd3, 5'b00000, 5'b01111, 1'b0},
               13'd0};
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            {i_stall, d_stall, div_start, div_done, load_use, exc_req} = vi[k];
            #1;
            obs = {state, stall, flush, div_cancel};
            if (ve[k][10:6] != 5'd0) exp_cnt++;
            checks++;
            if (obs !== ve[k]) begin
                errors++;
                $display("FAIL exc_fetch[%0d] got %h want %h", k, obs, ve[k]);
            end
        end
    endtask

    task automatic test_exc_div();
        logic [5:0]  vi [4];
        logic [12:0] ve [4];
        int          want;
        vi = '{6'b001000, 6'b000000, 6'b000001, 6'b000000};
        ve = '{{2'd0, 5'b00111, 5'b01000, 1'b0},
               {2'd2, 5'b00111, 5'b01000, 1'b0},
               {2'd2, 5'b00000, 5'b01111, 1'b1},
               13'd0};
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            {i_stall, d_stall, div_start, div_done, load_use, exc_req} = vi[k];
            #1;
            obs = {state, stall, flush, div_cancel};
            if (ve[k][10:6] != 5'd0) exp_cnt++;
            checks++;
            if (obs !== ve[k]) begin
                errors++;
                $display("FAIL exc_div[%0d] got %h want %h", k, obs, ve[k]);
            end
        end
`ifdef WAIT_CTRL_STALL_CNT_EN
        want = exp_cnt;
`else
        want = 0;
`endif
        checks++;
        if (stall_cnt !== 32'(want)) begin
            errors++;
            $display("FAIL stall_cnt got %0d want %0d", stall_cnt, want);
        end
    endtask

    task automatic test_reset_mid_div();
        @(negedge clk);
        {i_stall, d_stall, div_start, div_done, load_use, exc_req} = 6'b001000;
        @(negedge clk);
        {i_stall, d_stall, div_start, div_done, load_use, exc_req} = 6'b000000;
        #1;
        checks++;
        if (state !== 2'd2) begin
            errors++;
            $display("FAIL mid_div_state got %0d want 2", state);
        end
        @(negedge clk);
        resetn = 1'b0;
        {i_stall, d_stall, div_start, div_done, load_use, exc_req} = 6'b010001;
        #1;
        obs = {state, stall, flush, div_cancel};
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL mid_reset got %h want %h", obs, 13'd0);
        end
        checks++;
        if (stall_cnt !== 32'd0) begin
            errors++;
            $display("FAIL mid_reset_cnt got %0d want 0", stall_cnt);
        end
        @(negedge clk);
        resetn = 1'b1;
        {i_stall, d_stall, div_start, div_done, load_use, exc_req} = 6'b000000;
        exp_cnt = 0;
        @(negedge clk);
        #1;
        obs = {state, stall, flush, div_cancel};
        checks++;
        if (obs !== 13'd0) begin
            errors++;
            $display("FAIL after_reset got %h want %h", obs, 13'd0);
        end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        exp_cnt = 0;
        test_reset();
        test_load_use();
        test_fetch_wait();
        test_mem_wait();
        test_divide();
        test_div_mem_overlap();
        test_exc_fetch();
        test_exc_div();
        test_reset_mid_div();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
